iir_stream_ctrl: RTL

Sequencer for the pipelined_iir datapath. The filter has no enable and consumes one sample every clock, so this block owns its reset and its x input. It runs a start-to-done job of num_samp samples: flush the filter, stream samples, drain the pipeline, then pulse done. A valid-tag pipeline keeps out_valid aligned with filter output, and underruns are flagged.

---
 rtl/iir_ctrl_pkg.sv | 21 ++
 rtl/iir_valid_tag_pipe.sv | 33 +++
 rtl/iir_stream_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/iir_ctrl_pkg.sv
// Shared definitions for the pipelined_iir stream sequencer.
//   state_t      : job sequencer states
//   DEF_*        : default sample width, filter latency, flush length, counter width
//   ZERO_SAMP    : the sample driven into the filter when no data is issued
package iir_ctrl_pkg;

    localparam int unsigned DEF_W       = 32;
    localparam int unsigned DEF_LAT     = 4;
    localparam int unsigned DEF_RST_CYC = 3;
    localparam int unsigned DEF_CNT_W   = 16;

    localparam logic [DEF_W-1:0] ZERO_SAMP = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/iir_valid_tag_pipe.sv
// Valid-tag shift register that tracks which filter cycles carry job samples.
//   clk, reset : clock, async active-low reset
//   clr        : synchronous clear of every stage
//   tag_in     : 1 when a sample slot is issued this cycle
//   tag_out    : tag after DEPTH edges
import iir_ctrl_pkg::*;

module iir_valid_tag_pipe #(
    parameter int unsigned DEPTH = DEF_LAT + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic tag_in,
    output logic tag_out
);

    logic [DEPTH-1:0] pipe;

    // Stage 0 loads on the issue edge; stage DEPTH-1 is valid DEPTH-1 edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe <= '0;
        end else if (clr) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[DEPTH-2:0], tag_in};
        end
    end

    assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/iir_stream_ctrl.sv
// Start-to-done job sequencer for the pipelined_iir datapath: flushes the
// filter, streams num_samp samples into it, drains the pipeline, pulses done.
// Optional build macro IIR_CTRL_HOLD_EN: underrun slots repeat the last
// accepted sample instead of driving zero.
//   clk, reset        : clock, async active-low reset
//   start, stop       : begin job (IDLE only) / end streaming early (RUN only)
//   num_samp          : job length, latched on start
//   in_valid, in_data : upstream sample; in_ready high only while streaming
//   filt_rst, filt_x  : filter reset and sample input
//   filt_y            : filter output
//   out_valid, out_data : aligned filter result for job samples
//   busy, done, underrun, samp_cnt : job status
import iir_ctrl_pkg::*;

module iir_stream_ctrl #(
    parameter int unsigned W       = DEF_W,
    parameter int unsigned LAT     = DEF_LAT,
    parameter int unsigned RST_CYC = DEF_RST_CYC,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_samp,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             filt_rst,
    output logic [W-1:0]     filt_x,
    input  logic [W-1:0]     filt_y,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic [CNT_W-1:0] samp_cnt
);

    localparam int unsigned PH_MAX = (LAT + 1 > RST_CYC) ? LAT + 1 : RST_CYC;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    state_t           state, state_nxt;
    logic [PH_W-1:0]  ph_cnt, ph_nxt;
    logic [CNT_W-1:0] cnt_lat, cnt_lat_nxt;
    logic [CNT_W-1:0] samp_nxt;
    logic [W-1:0]     filt_x_nxt;
    logic             under_nxt;
    logic             done_nxt;
    logic             filt_rst_nxt;
    logic             in_ready_nxt;
    logic             busy_nxt;
    logic             slot_c;
    logic             job_clr_c;
    logic             tag_out;
`ifdef IIR_CTRL_HOLD_EN
    logic [W-1:0]     last_samp, last_nxt;
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ph_cnt   <= '0;
            cnt_lat  <= '0;
            samp_cnt <= '0;
            filt_x   <= '0;
            filt_rst <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
`ifdef IIR_CTRL_HOLD_EN
            last_samp <= '0;
`endif
        end else begin
            state    <= state_nxt;
            ph_cnt   <= ph_nxt;
            cnt_lat  <= cnt_lat_nxt;
            samp_cnt <= samp_nxt;
            filt_x   <= filt_x_nxt;
            filt_rst <= filt_rst_nxt;
            in_ready <= in_ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            underrun <= under_nxt;
`ifdef IIR_CTRL_HOLD_EN
            last_samp <= last_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        ph_nxt      = ph_cnt;
        cnt_lat_nxt = cnt_lat;
        samp_nxt    = samp_cnt;
        filt_x_nxt  = W'(ZERO_SAMP);
        under_nxt   = underrun;
        done_nxt    = 1'b0;
        slot_c      = 1'b0;
        job_clr_c   = 1'b0;
`ifdef IIR_CTRL_HOLD_EN
        last_nxt    = last_samp;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_lat_nxt = num_samp;
                    samp_nxt    = '0;
                    under_nxt   = 1'b0;
                    ph_nxt      = '0;
                    job_clr_c   = 1'b1;
`ifdef IIR_CTRL_HOLD_EN
                    last_nxt    = '0;
`endif
                    state_nxt   = FLUSH;
                end
            end
            FLUSH: begin
                if (ph_cnt == PH_W'(RST_CYC - 1)) begin
                    ph_nxt    = '0;
                    state_nxt = (cnt_lat == '0) ? DRAIN : RUN;
                end else begin
                    ph_nxt = PH_W'(ph_cnt + 1'b1);
                end
            end
            RUN: begin
                // Every RUN cycle issues one slot, valid data or not.
                slot_c   = 1'b1;
                samp_nxt = CNT_W'(samp_cnt + 1'b1);
                if (in_valid) begin
                    filt_x_nxt = in_data;
`ifdef IIR_CTRL_HOLD_EN
                    last_nxt   = in_data;
`endif
                end else begin
                    under_nxt = 1'b1;
`ifdef IIR_CTRL_HOLD_EN
                    filt_x_nxt = last_samp;
`endif
                end
                if (samp_nxt == cnt_lat || stop) begin
                    ph_nxt    = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (ph_cnt == PH_W'(LAT)) begin
                    ph_nxt    = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    ph_nxt = PH_W'(ph_cnt + 1'b1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Status outputs follow the state being entered so they match it cycle for cycle.
        filt_rst_nxt = (state_nxt == IDLE) || (state_nxt == FLUSH);
        in_ready_nxt = (state_nxt == RUN);
        busy_nxt     = (state_nxt != IDLE);
    end

    iir_valid_tag_pipe #(
        .DEPTH (LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .clr     (job_clr_c),
        .tag_in  (slot_c),
        .tag_out (tag_out)
    );

    // Capture filter output only for cycles that carry a job sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= tag_out;
            if (tag_out) begin
                out_data <= filt_y;
            end
        end
    end

endmodule
